// File: rtl/pasta_pkg.sv
// Shared PASTA datapath constants and lane/vector types.
package pasta_pkg;

    localparam int unsigned BITLEN     = 17;
    localparam int unsigned Q          = 65537;
    localparam int unsigned PASTA_S    = 32;
    localparam int unsigned MODMUL_LAT = 3;
    localparam int unsigned NREQ       = 3;
    localparam int unsigned LENW       = 6;
    localparam int unsigned PTRW       = $clog2(NREQ);
    localparam int unsigned CNTW       = LENW + 1;

    typedef logic [BITLEN-1:0]   lane_t;
    typedef lane_t [PASTA_S-1:0] lane_vec_t;
    typedef logic [LENW-1:0]     burst_len_t;
    typedef logic [CNTW-1:0]     burst_cnt_t;

    // Beat count of a burst; a zero length field means the maximum 2^LENW.
    function automatic burst_cnt_t burst_beats(input burst_len_t len);
        return (len == '0) ? burst_cnt_t'(1 << LENW) : burst_cnt_t'(len);
    endfunction

endpackage

// File: rtl/modmul_arbiter_if.sv
// Requester/bank side bundle of the modular-multiplier bank arbiter.
interface modmul_arbiter_if;
    import pasta_pkg::*;

    logic       [NREQ-1:0] req;
    burst_len_t [NREQ-1:0] req_len;
    lane_vec_t  [NREQ-1:0] req_in1;
    lane_vec_t  [NREQ-1:0] req_in2;
    logic       [NREQ-1:0] gnt;
    logic                  busy;
    lane_vec_t             mm_in1;
    lane_vec_t             mm_in2;
    lane_vec_t             mm_out;
    lane_vec_t             rsp_data;
    logic       [NREQ-1:0] rsp_valid;

    modport slave (
        input  req, req_len, req_in1, req_in2, mm_out,
        output gnt, busy, mm_in1, mm_in2, rsp_data, rsp_valid
    );

    modport master (
        output req, req_len, req_in1, req_in2, mm_out,
        input  gnt, busy, mm_in1, mm_in2, rsp_data, rsp_valid
    );
endinterface

// File: rtl/modmul_arbiter_rr_pick.sv
// Combinational round-robin winner select starting at ptr.
// MODMUL_ARB_PRIO_EN gives requester 0 fixed top priority.
module rr_pick
    import pasta_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [PTRW-1:0] ptr,
    output logic            any_c,
    output logic [NREQ-1:0] win_c,
    output logic [PTRW-1:0] win_idx_c
);

    logic [NREQ-1:0][PTRW-1:0] cand;

    // Search order: ptr, ptr+1, ... wrapping modulo NREQ.
    always_comb begin
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand[i] = PTRW'((32'(ptr) + i) % NREQ);
        end
    end

    always_comb begin
        any_c     = 1'b0;
        win_c     = '0;
        win_idx_c = '0;
`ifdef MODMUL_ARB_PRIO_EN
        if (req[0]) begin
            any_c    = 1'b1;
            win_c[0] = 1'b1;
        end
`endif
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!any_c && req[cand[i]]) begin
                any_c          = 1'b1;
                win_c[cand[i]] = 1'b1;
                win_idx_c      = cand[i];
            end
        end
    end

endmodule

// File: rtl/modmul_arbiter.sv
// Burst arbiter for the shared PASTA_S-lane modmul bank with tagged result return.
// Optional MODMUL_ARB_PRIO_EN: requester 0 wins every arbitration point.
module modmul_arbiter
    import pasta_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    modmul_arbiter_if.slave bus
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                           state_q, state_nx;
    logic       [NREQ-1:0]            gnt_q, gnt_nx;
    burst_cnt_t                       cnt_q, cnt_nx;
    logic       [PTRW-1:0]            ptr_q, ptr_nx;
    logic                             busy_q;
    logic       [MODMUL_LAT-1:0][NREQ-1:0] tag_q;

    logic                             arb_en;
    logic                             pick_any;
    logic       [NREQ-1:0]            pick_win;
    logic       [PTRW-1:0]            pick_idx;
    logic       [PTRW-1:0]            ptr_after;
    lane_vec_t                        sel_in1, sel_in2;

    rr_pick u_rr_pick (
        .req       (bus.req),
        .ptr       (ptr_q),
        .any_c     (pick_any),
        .win_c     (pick_win),
        .win_idx_c (pick_idx)
    );

    assign ptr_after = (pick_idx == PTRW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;

    // Next-state: arbitrate in IDLE or on the last beat, otherwise count beats.
    always_comb begin
        state_nx = state_q;
        gnt_nx   = gnt_q;
        cnt_nx   = cnt_q;
        ptr_nx   = ptr_q;
        arb_en   = 1'b0;
        case (state_q)
            IDLE:  arb_en = 1'b1;
            BURST: begin
                if (cnt_q == burst_cnt_t'(1)) begin
                    arb_en = 1'b1;
                end else begin
                    cnt_nx = cnt_q - 1'b1;
                end
            end
            default: arb_en = 1'b1;
        endcase
        if (arb_en) begin
            if (pick_any) begin
                state_nx = BURST;
                gnt_nx   = pick_win;
                cnt_nx   = burst_beats(bus.req_len[pick_idx]);
`ifdef MODMUL_ARB_PRIO_EN
                // Priority grants to requester 0 leave the rotation of the others untouched.
                if (pick_idx != '0) begin
                    ptr_nx = ptr_after;
                end
`else
                ptr_nx   = ptr_after;
`endif
            end else begin
                state_nx = IDLE;
                gnt_nx   = '0;
                cnt_nx   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            tag_q   <= '0;
        end else begin
            state_q <= state_nx;
            gnt_q   <= gnt_nx;
            cnt_q   <= cnt_nx;
            ptr_q   <= ptr_nx;
            busy_q  <= |gnt_nx;
            tag_q   <= {tag_q[MODMUL_LAT-2:0], gnt_q};
        end
    end

    // One-hot AND-OR operand mux; all-zero when nothing is granted.
    always_comb begin
        sel_in1 = '0;
        sel_in2 = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (gnt_q[k]) begin
                sel_in1 = sel_in1 | bus.req_in1[k];
                sel_in2 = sel_in2 | bus.req_in2[k];
            end
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.busy      = busy_q;
    assign bus.mm_in1    = sel_in1;
    assign bus.mm_in2    = sel_in2;
    assign bus.rsp_valid = tag_q[MODMUL_LAT-1];
    assign bus.rsp_data  = bus.mm_out;

endmodule

// File: tb/tb_modmul_arbiter.sv
// Directed bench for modmul_arbiter with a behavioural MODMUL_LAT-deep modmul bank.
module tb_modmul_arbiter;
    import pasta_pkg::*;

    localparam int unsigned VW = PASTA_S * BITLEN;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_fail;
    logic [MODMUL_LAT-1:0][NREQ-1:0] hist;
    lane_vec_t bank_p [MODMUL_LAT];

    modmul_arbiter_if bus ();

    modmul_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic lane_vec_t vec_a(input int k, input int c);
        lane_vec_t v;
        for (int l = 0; l < int'(PASTA_S); l++) begin
            if (l == 0) v[l] = BITLEN'(Q - 1);
            else        v[l] = BITLEN'((longint'(k) * 7919 + longint'(c) * 131 + longint'(l) * 977 + 1) % Q);
        end
        return v;
    endfunction

    function automatic lane_vec_t vec_b(input int k, input int c);
        lane_vec_t v;
        for (int l = 0; l < int'(PASTA_S); l++) begin
            v[l] = BITLEN'((longint'(k) * 40503 + longint'(c) * 613 + longint'(l) * 3301 + 65000) % Q);
        end
        return v;
    endfunction

    function automatic lane_vec_t mul_vec(input lane_vec_t a, input lane_vec_t b);
        lane_vec_t v;
        for (int l = 0; l < int'(PASTA_S); l++) begin
            v[l] = BITLEN'((longint'(a[l]) * longint'(b[l])) % Q);
        end
        return v;
    endfunction

    function automatic int oh_idx(input logic [NREQ-1:0] oh);
        int r;
        r = 0;
        for (int i = 0; i < int'(NREQ); i++) if (oh[i]) r = i;
        return r;
    endfunction

    for (genvar g = 0; g < int'(NREQ); g++) begin : g_ops
        assign bus.req_in1[g] = vec_a(g, cyc);
        assign bus.req_in2[g] = vec_b(g, cyc);
    end

    // Behavioural bank: (a*b) mod Q per lane, MODMUL_LAT cycles from inputs to output.
    always @(posedge clk) begin
        bank_p[0] <= mul_vec(bus.mm_in1, bus.mm_in2);
        for (int i = 1; i < int'(MODMUL_LAT); i++) bank_p[i] <= bank_p[i-1];
    end
    assign bus.mm_out = bank_p[MODMUL_LAT-1];

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // One clock; eg is the grant expected in the new cycle.
    task automatic step(input logic [NREQ-1:0] eg);
        lane_vec_t e1, e2;
        @(posedge clk);
        #1;
        e1 = (eg != '0) ? vec_a(oh_idx(eg), cyc) : '0;
        e2 = (eg != '0) ? vec_b(oh_idx(eg), cyc) : '0;
        check("gnt", VW'(bus.gnt), VW'(eg));
        check("busy", VW'(bus.busy), VW'(|eg));
        check("mm_in1", bus.mm_in1, e1);
        check("mm_in2", bus.mm_in2, e2);
        check("rsp_valid", VW'(bus.rsp_valid), VW'(hist[MODMUL_LAT-1]));
        if (hist[MODMUL_LAT-1] != '0)
            check("rsp_data", bus.rsp_data, mul_vec(vec_a(oh_idx(hist[MODMUL_LAT-1]), cyc - int'(MODMUL_LAT)),
                                                    vec_b(oh_idx(hist[MODMUL_LAT-1]), cyc - int'(MODMUL_LAT))));
        check("gnt_onehot", VW'($onehot0(bus.gnt)), VW'(1));
        check("rsp_onehot", VW'($onehot0(bus.rsp_valid)), VW'(1));
        hist = {hist[MODMUL_LAT-2:0], eg};
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0);
    endtask

    task automatic issue(input int k, input burst_len_t len);
        bus.req[k]     = 1'b1;
        bus.req_len[k] = len;
    endtask

    // Expect a burst of `beats` for requester k; k withdraws req once granted.
    task automatic run_burst(input int k, input int beats);
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[k] = 1'b1;
        for (int i = 0; i < beats; i++) begin
            step(oh);
            if (i == 0) bus.req[k] = 1'b0;
        end
    endtask

    // Asynchronous reset: outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_gnt", VW'(bus.gnt), VW'(0));
        check("rst_busy", VW'(bus.busy), VW'(0));
        check("rst_rsp_valid", VW'(bus.rsp_valid), VW'(0));
        check("rst_mm_in1", bus.mm_in1, '0);
        check("rst_mm_in2", bus.mm_in2, '0);
        hist    = '0;
        bus.req = '0;
        step('0);
        step('0);
        rst_n = 1'b1;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        hist        = '0;
        bus.req     = '0;
        bus.req_len = '0;
        do_reset();

        // Single requester, len 32; length change after grant is ignored.
        issue(1, 6'd32);
        step(3'b010);
        bus.req[1]     = 1'b0;
        bus.req_len[1] = 6'd5;
        run_burst(1, 31);
        idle(4);

        // Fairness: all three request, order 0,1,2,0 with no gaps.
        do_reset();
        issue(0, 6'd4);
        issue(1, 6'd4);
        issue(2, 6'd4);
        run_burst(0, 4);
        run_burst(1, 4);
        step(3'b100);
        bus.req[2] = 1'b0;
        issue(0, 6'd4);
        for (int i = 0; i < 3; i++) step(3'b100);
        run_burst(0, 4);
        idle(4);

        // len=0 means 64 beats, len=1 is a single beat.
        issue(2, 6'd0);
        run_burst(2, 64);
        idle(4);
        issue(0, 6'd1);
        run_burst(0, 1);
        idle(4);

        // Two len=1 requesters held high alternate every cycle.
        do_reset();
        issue(1, 6'd1);
        issue(2, 6'd1);
        for (int i = 0; i < 6; i++) begin
            step((i % 2 == 0) ? 3'b010 : 3'b100);
            if (i == 5) bus.req = '0;
        end
        idle(4);

        // Reset at beat 10 of a 32-beat burst, then stay quiet.
        do_reset();
        issue(1, 6'd32);
        run_burst(1, 10);
        do_reset();
        idle(5);

        // Drain: in-flight results of owner 0 are followed directly by owner 2.
        issue(0, 6'd4);
        issue(2, 6'd3);
        run_burst(0, 4);
        run_burst(2, 3);
        idle(4);

        // Requesters 0 and 2 queue while 1 is bursting.
        do_reset();
        issue(1, 6'd5);
        step(3'b010);
        bus.req[1] = 1'b0;
        issue(0, 6'd2);
        issue(2, 6'd2);
        for (int i = 0; i < 4; i++) step(3'b010);
`ifdef MODMUL_ARB_PRIO_EN
        run_burst(0, 2);
        run_burst(2, 2);
`else
        run_burst(2, 2);
        run_burst(0, 2);
`endif
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
